// File: rtl/mem_access_stage_pkg.sv
// Shared widths, memory-op codes, FSM state codes and decode helpers for the MEM stage.
package mem_access_stage_pkg;

    localparam int unsigned RegW     = 32;
    localparam int unsigned RegAddrW = 5;
    localparam int unsigned MemOpW   = 4;

    localparam logic [MemOpW-1:0] MEM_NOP = 4'd0;
    localparam logic [MemOpW-1:0] MEM_LB  = 4'd1;
    localparam logic [MemOpW-1:0] MEM_LH  = 4'd2;
    localparam logic [MemOpW-1:0] MEM_LW  = 4'd3;
    localparam logic [MemOpW-1:0] MEM_LBU = 4'd4;
    localparam logic [MemOpW-1:0] MEM_LHU = 4'd5;
    localparam logic [MemOpW-1:0] MEM_SB  = 4'd6;
    localparam logic [MemOpW-1:0] MEM_SH  = 4'd7;
    localparam logic [MemOpW-1:0] MEM_SW  = 4'd8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic is_load(logic [MemOpW-1:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(logic [MemOpW-1:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(logic [MemOpW-1:0] op, logic [1:0] offset);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return offset[0];
            MEM_LW, MEM_SW:          return offset != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Formats a raw bus read word into the register value for a given load op and byte offset.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [MemOpW-1:0] op,
    input  logic [1:0]        offset,
    input  logic [RegW-1:0]   rdata,
    output logic [RegW-1:0]   data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data = {24'h0, byte_sel};
            MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data = {16'h0, half_sel};
            MEM_LW:  data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues one load/store at a time on a req/ready bus and produces the MEM/WB triple.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [RegAddrW-1:0] ex_reg_waddr,
    input  logic                ex_we,
    input  logic [RegW-1:0]     ex_reg_wdata,
    input  logic [MemOpW-1:0]   ex_mem_op,
    input  logic [RegW-1:0]     ex_mem_addr,
    input  logic [RegW-1:0]     ex_mem_sdata,
    output logic                ram_req,
    output logic                ram_we,
    output logic [RegW-1:0]     ram_addr,
    output logic [RegW-1:0]     ram_wdata,
    output logic [3:0]          ram_wmask,
    input  logic                ram_ready,
    input  logic [RegW-1:0]     ram_rdata,
    output logic [RegAddrW-1:0] mem_reg_waddr,
    output logic                mem_we,
    output logic [RegW-1:0]     mem_reg_wdata,
    output logic                misalign,
    output logic                stallreq
);

    logic [1:0]          state_q, state_d;
    logic [MemOpW-1:0]   op_q;
    logic [1:0]          off_q;
    logic [RegAddrW-1:0] waddr_q;
    logic                we_q;
    logic [RegW-1:0]     alu_q;
    logic [RegW-1:0]     result_q;
    logic                ram_req_q, ram_we_q;
    logic [RegW-1:0]     ram_addr_q, ram_wdata_q;
    logic [3:0]          ram_wmask_q;

    logic            is_mem, misaligned_op, start;
    logic [RegW-1:0] st_wdata, load_data;
    logic [3:0]      st_wmask;

    mem_load_align u_load_align (
        .op     (op_q),
        .offset (off_q),
        .rdata  (ram_rdata),
        .data   (load_data)
    );

    assign is_mem        = is_load(ex_mem_op) | is_store(ex_mem_op);
    assign misaligned_op = is_mem & is_misaligned(ex_mem_op, ex_mem_addr[1:0]);
    assign start         = (state_q == StIdle) & is_mem & ~misaligned_op;

    always_comb begin
        st_wdata = '0;
        st_wmask = 4'b0000;
        case (ex_mem_op)
            MEM_SB: begin
                st_wdata = {4{ex_mem_sdata[7:0]}};
                st_wmask = 4'b0001 << ex_mem_addr[1:0];
            end
            MEM_SH: begin
                st_wdata = {2{ex_mem_sdata[15:0]}};
                st_wmask = 4'b0011 << {ex_mem_addr[1], 1'b0};
            end
            MEM_SW: begin
                st_wdata = ex_mem_sdata;
                st_wmask = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StReq;
            StReq:   if (ram_ready) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= MEM_NOP;
            off_q       <= 2'b00;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            alu_q       <= '0;
            result_q    <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wmask_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (start) begin
                ram_req_q   <= 1'b1;
                ram_we_q    <= is_store(ex_mem_op);
                ram_addr_q  <= {ex_mem_addr[RegW-1:2], 2'b00};
                ram_wdata_q <= st_wdata;
                ram_wmask_q <= st_wmask;
                op_q        <= ex_mem_op;
                off_q       <= ex_mem_addr[1:0];
                waddr_q     <= ex_reg_waddr;
                we_q        <= ex_we;
                alu_q       <= ex_reg_wdata;
            end
            if ((state_q == StReq) && ram_ready) begin
                ram_req_q <= 1'b0;
                // Formatter yields 0 for stores, so stores capture 0.
                result_q  <= load_data;
            end
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wmask = ram_wmask_q;

    always_comb begin
        mem_reg_waddr = ex_reg_waddr;
        mem_we        = ex_we;
        mem_reg_wdata = ex_reg_wdata;
        stallreq      = 1'b0;
        misalign      = 1'b0;
        if (rst) begin
            mem_reg_waddr = '0;
            mem_we        = 1'b0;
            mem_reg_wdata = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (misaligned_op) begin
                        misalign = 1'b1;
                        mem_we   = 1'b0;
                    end else if (is_mem) begin
                        stallreq = 1'b1;
                        mem_we   = 1'b0;
                    end
                end
                StReq: begin
                    mem_reg_waddr = waddr_q;
                    mem_we        = 1'b0;
                    mem_reg_wdata = '0;
                    stallreq      = 1'b1;
                end
                StDone: begin
                    mem_reg_waddr = waddr_q;
                    mem_we        = we_q;
                    mem_reg_wdata = is_load(op_q) ? result_q : alu_q;
                end
                default: begin
                    mem_reg_waddr = '0;
                    mem_we        = 1'b0;
                    mem_reg_wdata = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage against a transaction-level model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_reg_waddr;
    logic        ex_we;
    logic [31:0] ex_reg_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_sdata;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_wmask;
    logic        ram_ready;
    logic [31:0] ram_rdata;
    logic [4:0]  mem_reg_waddr;
    logic        mem_we;
    logic [31:0] mem_reg_wdata;
    logic        misalign, stallreq;

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_reg_waddr  (ex_reg_waddr),
        .ex_we         (ex_we),
        .ex_reg_wdata  (ex_reg_wdata),
        .ex_mem_op     (ex_mem_op),
        .ex_mem_addr   (ex_mem_addr),
        .ex_mem_sdata  (ex_mem_sdata),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_wmask     (ram_wmask),
        .ram_ready     (ram_ready),
        .ram_rdata     (ram_rdata),
        .mem_reg_waddr (mem_reg_waddr),
        .mem_we        (mem_we),
        .mem_reg_wdata (mem_reg_wdata),
        .misalign      (misalign),
        .stallreq      (stallreq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Per-cycle expectations, written by the driver and checked at the falling edge.
    logic        chk_en = 1'b0, chk_data = 1'b0, chk_bus = 1'b0;
    logic        exp_stall, exp_mis, exp_we, exp_req, exp_ram_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata, exp_ram_addr, exp_ram_wdata;
    logic [3:0]  exp_ram_wmask;
    logic [31:0] last_wdata, last_ram_addr, last_ram_wdata;
    logic [3:0]  last_ram_wmask;
    logic        last_ram_we;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check1("stallreq", stallreq, exp_stall);
            check1("misalign", misalign, exp_mis);
            check1("mem_we", mem_we, exp_we);
            check1("ram_req", ram_req, exp_req);
            if (chk_data) begin
                check32("mem_reg_waddr", {27'b0, mem_reg_waddr}, {27'b0, exp_waddr});
                check32("mem_reg_wdata", mem_reg_wdata, exp_wdata);
                last_wdata = mem_reg_wdata;
            end
            if (chk_bus) begin
                check1("ram_we", ram_we, exp_ram_we);
                check32("ram_addr", ram_addr, exp_ram_addr);
                check32("ram_wdata", ram_wdata, exp_ram_wdata);
                check32("ram_wmask", {28'b0, ram_wmask}, {28'b0, exp_ram_wmask});
                last_ram_addr  = ram_addr;
                last_ram_wdata = ram_wdata;
                last_ram_wmask = ram_wmask;
                last_ram_we    = ram_we;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit m_is_load(logic [3:0] op);
        return op >= 4'd1 && op <= 4'd5;
    endfunction

    function automatic bit m_is_mem(logic [3:0] op);
        return op >= 4'd1 && op <= 4'd8;
    endfunction

    function automatic bit m_misaligned(logic [3:0] op, logic [31:0] addr);
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) return (addr % 2) != 0;
        if (op == 4'd3 || op == 4'd8) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(logic [3:0] op, logic [31:0] addr, logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            4'd1: return b - ((b & 32'h80) << 1);
            4'd2: return h - ((h & 32'h8000) << 1);
            4'd3: return rd;
            4'd4: return b;
            4'd5: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_st_wdata(logic [3:0] op, logic [31:0] sd);
        case (op)
            4'd6: return (sd & 32'hFF) * 32'h0101_0101;
            4'd7: return (sd & 32'hFFFF) * 32'h0001_0001;
            4'd8: return sd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] m_st_wmask(logic [3:0] op, logic [31:0] addr);
        logic [3:0] one, two;
        one = 4'b0001;
        two = 4'b0011;
        case (op)
            4'd6: return one << (addr % 4);
            4'd7: return two << (2 * ((addr / 2) % 2));
            4'd8: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic set_exp(input logic stall, input logic mis, input logic we, input logic req);
        exp_stall = stall;
        exp_mis   = mis;
        exp_we    = we;
        exp_req   = req;
        chk_data  = 1'b0;
        chk_bus   = 1'b0;
    endtask

    // One EX/MEM instruction, held on the inputs until the stage accepts it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] wa, input logic we, input logic [31:0] alu,
                          input int delay, input logic pre_pulse, input logic [31:0] rd);
        @(posedge clk); #1;
        ex_mem_op = op; ex_mem_addr = addr; ex_mem_sdata = sd;
        ex_reg_waddr = wa; ex_we = we; ex_reg_wdata = alu;
        ram_ready = 1'b0; ram_rdata = $urandom;
        chk_en = 1'b1;
        if (!m_is_mem(op)) begin
            set_exp(1'b0, 1'b0, we, 1'b0);
            chk_data = 1'b1; exp_waddr = wa; exp_wdata = alu;
        end else if (m_misaligned(op, addr)) begin
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
            ram_ready = pre_pulse;
            for (int k = 1; k <= delay; k++) begin
                @(posedge clk); #1;
                ram_ready = (k == delay);
                ram_rdata = (k == delay) ? rd : $urandom;
                set_exp(1'b1, 1'b0, 1'b0, 1'b1);
                chk_bus = 1'b1;
                exp_ram_we = !m_is_load(op);
                exp_ram_addr = addr & ~32'h3;
                exp_ram_wdata = m_st_wdata(op, sd);
                exp_ram_wmask = m_st_wmask(op, addr);
            end
            @(posedge clk); #1;
            ram_ready = 1'($urandom_range(0, 1));
            ram_rdata = $urandom;
            set_exp(1'b0, 1'b0, we, 1'b0);
            chk_data = 1'b1; exp_waddr = wa;
            exp_wdata = m_is_load(op) ? m_load(op, addr, rd) : alu;
        end
        @(negedge clk); #1;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr;
        rst = 1'b1;
        ex_mem_op = 4'd0; ex_mem_addr = 32'h0; ex_mem_sdata = 32'h0;
        ex_reg_waddr = 5'd7; ex_we = 1'b1; ex_reg_wdata = 32'hDEAD_BEEF;
        ram_ready = 1'b0; ram_rdata = 32'h0;
        #12;
        check1("reset ram_req", ram_req, 1'b0);
        check1("reset stallreq", stallreq, 1'b0);
        check1("reset mem_we", mem_we, 1'b0);
        check32("reset mem_reg_wdata", mem_reg_wdata, 32'h0);
        check32("reset ram_addr", ram_addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        run_op(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 1'b0, 32'h0);
        check32("nop pass wdata", last_wdata, 32'h0000_1234);
        run_op(4'd1, 32'h103, 32'h0, 5'd3, 1'b1, 32'h0, 1, 1'b0, 32'h80FF_1122);
        check32("lb ram_addr", last_ram_addr, 32'h0000_0100);
        check32("lb result", last_wdata, 32'hFFFF_FF80);
        run_op(4'd4, 32'h103, 32'h0, 5'd3, 1'b1, 32'h0, 1, 1'b0, 32'h80FF_1122);
        check32("lbu result", last_wdata, 32'h0000_0080);
        run_op(4'd7, 32'h202, 32'hABCD_5678, 5'd9, 1'b0, 32'h202, 1, 1'b0, 32'h0);
        check1("sh ram_we", last_ram_we, 1'b1);
        check32("sh ram_wmask", {28'b0, last_ram_wmask}, 32'hC);
        check32("sh ram_wdata", last_ram_wdata, 32'h5678_5678);
        run_op(4'd3, 32'h400, 32'h0, 5'd11, 1'b1, 32'h0, 5, 1'b1, 32'hCAFE_F00D);
        check32("lw delayed result", last_wdata, 32'hCAFE_F00D);
        run_op(4'd3, 32'h101, 32'h0, 5'd12, 1'b1, 32'h0, 1, 1'b0, 32'h0);
        run_op(4'd0, 32'h0, 32'h0, 5'd1, 1'b0, 32'h55, 0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of an access.
        @(posedge clk); #1;
        ex_mem_op = 4'd3; ex_mem_addr = 32'h800; ex_reg_waddr = 5'd4; ex_we = 1'b1;
        ram_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check1("async rst ram_req", ram_req, 1'b0);
        check1("async rst stallreq", stallreq, 1'b0);
        ex_mem_op = 4'd0;
        @(posedge clk); #3 rst = 1'b0;
        run_op(4'd3, 32'h804, 32'h0, 5'd4, 1'b1, 32'h0, 2, 1'b0, 32'h1357_9BDF);
        check32("lw after rst", last_wdata, 32'h1357_9BDF);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 8));
            raddr = $urandom;
            if ($urandom_range(0, 2) != 0) raddr[1:0] = 2'b00;
            else if ($urandom_range(0, 1) != 0) raddr[0] = 1'b0;
            run_op(rop, raddr, $urandom, 5'($urandom), 1'($urandom), $urandom,
                   $urandom_range(1, 4), 1'($urandom), $urandom);
        end
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
